// File: rtl/tdx_cpu.sv
// tdx_cpu: tiny accumulator-style processor with a writable program memory.
//
// Ports
//   clock      rising-edge clock for all state
//   reset_n    asynchronous active-low reset (program memory is not cleared)
//   in_port    external input operand (DATA_W)
//   prog_we    program-memory write strobe, honoured only outside RUN
//   prog_addr  program-memory write address (PC_W)
//   prog_data  program-memory write data (INSTR_W)
//   start      enter RUN at PC 0 from LOAD or HALTED
//   step_mode  1 = execute only on step pulses, 0 = one instruction per cycle
//   step       single-step pulse
//   pc_out     current program counter
//   op         instruction word at the current PC
//   out_port   OUT register
//   alu_data   ALU result for the current instruction
//   running    high in RUN
//   halted     high in HALTED
module tdx_cpu #(
  parameter int DATA_W = 4,
  parameter int PC_W   = 4,
  localparam int INSTR_W = 4 + DATA_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [DATA_W-1:0]  in_port,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               start,
  input  logic               step_mode,
  input  logic               step,
  output logic [PC_W-1:0]    pc_out,
  output logic [INSTR_W-1:0] op,
  output logic [DATA_W-1:0]  out_port,
  output logic [DATA_W-1:0]  alu_data,
  output logic               running,
  output logic               halted
);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALTED} state_t;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_JZ     = 4'b1000;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_A  = 4'b1010;
  localparam logic [3:0] OP_OUT_I  = 4'b1011;
  localparam logic [3:0] OP_HALT   = 4'b1100;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  logic [INSTR_W-1:0] mem [0:(1<<PC_W)-1];

  state_t            state, state_nxt;
  logic [PC_W-1:0]   pc, pc_nxt;
  logic [DATA_W-1:0] reg_a, reg_b, reg_out;
  logic [DATA_W-1:0] a_nxt, b_nxt, out_nxt;
  logic              flag_c, flag_z, c_nxt, z_nxt;

  logic [3:0]        opcode;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] src;
  logic [DATA_W:0]   sum;
  logic              writes_reg;
  logic              exec;

  assign op     = mem[pc];
  assign opcode = op[INSTR_W-1:DATA_W];
  assign imm    = op[DATA_W-1:0];

  // Operand select: each writing opcode adds IM to one of A, B, in_port or zero.
  always_comb begin
    src = '0;
    case (opcode)
      OP_ADD_A, OP_MOV_BA, OP_OUT_A: src = reg_a;
      OP_MOV_AB, OP_ADD_B, OP_OUT_B: src = reg_b;
      OP_IN_A, OP_IN_B:              src = in_port;
      default:                       src = '0;
    endcase
  end

  assign sum        = {1'b0, src} + {1'b0, imm};
  assign alu_data   = sum[DATA_W-1:0];
  assign writes_reg = !opcode[3] || (opcode == OP_OUT_B) || (opcode == OP_OUT_A) ||
                      (opcode == OP_OUT_I);
  assign exec       = (state == S_RUN) && (!step_mode || step);

  // Program memory: no reset, so a loaded program survives reset_n.
  always_ff @(posedge clock) begin
    if (prog_we && (state != S_RUN)) mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_LOAD;
      pc      <= '0;
      reg_a   <= '0;
      reg_b   <= '0;
      reg_out <= '0;
      flag_c  <= 1'b0;
      flag_z  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      reg_a   <= a_nxt;
      reg_b   <= b_nxt;
      reg_out <= out_nxt;
      flag_c  <= c_nxt;
      flag_z  <= z_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    a_nxt     = reg_a;
    b_nxt     = reg_b;
    out_nxt   = reg_out;
    c_nxt     = flag_c;
    z_nxt     = flag_z;
    case (state)
      S_LOAD, S_HALTED: begin
        if (start) begin
          state_nxt = S_RUN;
          pc_nxt    = '0;
          c_nxt     = 1'b0;
          z_nxt     = 1'b0;
        end
      end
      S_RUN: begin
        if (exec) begin
          pc_nxt = pc + PC_W'(1);
          case (opcode)
            OP_ADD_A, OP_MOV_AB, OP_IN_A, OP_MOV_AI: a_nxt   = alu_data;
            OP_MOV_BA, OP_ADD_B, OP_IN_B, OP_MOV_BI: b_nxt   = alu_data;
            OP_OUT_B, OP_OUT_A, OP_OUT_I:            out_nxt = alu_data;
            OP_JZ:   if (flag_z)  pc_nxt = imm[PC_W-1:0];
            OP_JNC:  if (!flag_c) pc_nxt = imm[PC_W-1:0];
            OP_JMP:  pc_nxt = imm[PC_W-1:0];
            // HALT holds the PC so pc_out still shows the HALT address.
            OP_HALT: begin
              pc_nxt    = pc;
              state_nxt = S_HALTED;
            end
            default: ;
          endcase
          if (writes_reg) begin
            c_nxt = sum[DATA_W];
            z_nxt = (alu_data == '0);
          end
        end
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  assign pc_out   = pc;
  assign out_port = reg_out;
  assign running  = (state == S_RUN);
  assign halted   = (state == S_HALTED);

endmodule

// File: tb/tb_tdx_cpu.sv
// Testbench for tdx_cpu: directed programs with hand-computed expectations,
// plus a second instance at DATA_W=8, PC_W=5.
module tb_tdx_cpu;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] in_port = '0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic       start = 1'b0;
  logic       step_mode = 1'b0;
  logic       step = 1'b0;
  logic [3:0] pc_out;
  logic [7:0] op;
  logic [3:0] out_port;
  logic [3:0] alu_data;
  logic       running;
  logic       halted;

  logic [7:0]  w_in = '0;
  logic        w_we = 1'b0;
  logic [4:0]  w_addr = '0;
  logic [11:0] w_data = '0;
  logic        w_start = 1'b0;
  logic        w_step_mode = 1'b0;
  logic        w_step = 1'b0;
  logic [4:0]  w_pc;
  logic [11:0] w_op;
  logic [7:0]  w_out;
  logic [7:0]  w_alu;
  logic        w_running;
  logic        w_halted;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  tdx_cpu #(.DATA_W(4), .PC_W(4)) dut (
    .clock(clock), .reset_n(reset_n), .in_port(in_port), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .start(start),
    .step_mode(step_mode), .step(step), .pc_out(pc_out), .op(op),
    .out_port(out_port), .alu_data(alu_data), .running(running), .halted(halted)
  );

  tdx_cpu #(.DATA_W(8), .PC_W(5)) dut_w (
    .clock(clock), .reset_n(reset_n), .in_port(w_in), .prog_we(w_we),
    .prog_addr(w_addr), .prog_data(w_data), .start(w_start),
    .step_mode(w_step_mode), .step(w_step), .pc_out(w_pc), .op(w_op),
    .out_port(w_out), .alu_data(w_alu), .running(w_running), .halted(w_halted)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input logic [3:0] a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Reset asserted and released between clock edges.
  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #2;
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %0b expected 0", running); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b expected 0", halted); end
    checks++; if (out_port !== 4'h0) begin errors++; $display("FAIL reset_out: got %0h expected 0", out_port); end
    checks++; if (pc_out !== 4'h0) begin errors++; $display("FAIL reset_pc: got %0h expected 0", pc_out); end
    tick();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_held_running: got %0b expected 0", running); end
    reset_n = 1'b1;
    tick();
  endtask

  // Last word written in the same cycle as start.
  task automatic test_program();
    logic [7:0] prog [0:5];
    prog = '{8'h37, 8'h09, 8'hE4, 8'hBF, 8'hB1, 8'hC0};
    for (int i = 1; i < 6; i++) load_word(4'(i), prog[i]);
    prog_we = 1'b1; prog_addr = 4'h0; prog_data = prog[0]; start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL prog_running: got %0b expected 1", running); end
    checks++; if (op !== 8'h37) begin errors++; $display("FAIL prog_first_fetch: got %0h expected 37", op); end
    checks++; if (alu_data !== 4'h7) begin errors++; $display("FAIL prog_alu_mov: got %0h expected 7", alu_data); end
    tick();
    checks++; if (alu_data !== 4'h0) begin errors++; $display("FAIL prog_alu_add: got %0h expected 0", alu_data); end
    tick();
    checks++; if (pc_out !== 4'h2) begin errors++; $display("FAIL prog_pc_jnc: got %0h expected 2", pc_out); end
    tick();
    checks++; if (pc_out !== 4'h3) begin errors++; $display("FAIL prog_jnc_not_taken: got %0h expected 3", pc_out); end
    tick();
    checks++; if (out_port !== 4'hF) begin errors++; $display("FAIL prog_out_f: got %0h expected f", out_port); end
    tick();
    checks++; if (out_port !== 4'h1) begin errors++; $display("FAIL prog_out_1: got %0h expected 1", out_port); end
    checks++; if (pc_out !== 4'h5) begin errors++; $display("FAIL prog_pc_halt: got %0h expected 5", pc_out); end
    tick();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL prog_halted: got %0b expected 1", halted); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL prog_not_running: got %0b expected 0", running); end
    tick();
    checks++; if (pc_out !== 4'h5) begin errors++; $display("FAIL prog_pc_held: got %0h expected 5", pc_out); end
  endtask

  task automatic test_halt_restart();
    pulse_start();
    checks++; if (pc_out !== 4'h0 || running !== 1'b1) begin errors++; $display("FAIL restart_entry: got pc %0h run %0b expected pc 0 run 1", pc_out, running); end
    for (int i = 0; i < 4; i++) tick();
    checks++; if (out_port !== 4'hF) begin errors++; $display("FAIL restart_out_f: got %0h expected f", out_port); end
    tick(); tick();
    checks++; if (halted !== 1'b1 || pc_out !== 4'h5) begin errors++; $display("FAIL restart_halt: got halted %0b pc %0h expected 1 5", halted, pc_out); end
  endtask

  task automatic test_reset_midrun();
    load_word(4'h0, 8'hBA);
    load_word(4'h1, 8'hF1);
    pulse_start();
    tick(); tick();
    checks++; if (out_port !== 4'hA) begin errors++; $display("FAIL midrun_out_a: got %0h expected a", out_port); end
    reset_n = 1'b0;
    #1;
    checks++; if (out_port !== 4'h0) begin errors++; $display("FAIL midrun_out_cleared: got %0h expected 0", out_port); end
    checks++; if (running !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL midrun_state: got run %0b halt %0b expected 0 0", running, halted); end
    checks++; if (pc_out !== 4'h0) begin errors++; $display("FAIL midrun_pc: got %0h expected 0", pc_out); end
    #1;
    reset_n = 1'b1;
    checks++; if (op !== 8'hBA) begin errors++; $display("FAIL midrun_mem_intact: got %0h expected ba", op); end
    tick();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL midrun_load_state: got %0b expected 0", running); end
    pulse_start();
    tick();
    checks++; if (out_port !== 4'hA || op !== 8'hF1) begin errors++; $display("FAIL midrun_rerun: got out %0h op %0h expected a f1", out_port, op); end
  endtask

  task automatic test_jmp_loop();
    do_reset();
    for (int i = 0; i < 16; i++) load_word(4'(i), 8'hF0);
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      checks++; if (pc_out !== 4'h0 || running !== 1'b1) begin errors++; $display("FAIL jmp_loop[%0d]: got pc %0h run %0b expected 0 1", i, pc_out, running); end
      tick();
    end
  endtask

  // Flag state across NOPs is observed through the JZ at address 0 on wrap.
  task automatic test_nop_wrap();
    do_reset();
    load_word(4'h0, 8'h83);
    load_word(4'h1, 8'h30);
    for (int i = 2; i < 16; i++) load_word(4'(i), 8'hD0);
    pulse_start();
    for (int i = 1; i < 16; i++) begin
      tick();
      checks++; if (pc_out !== 4'(i)) begin errors++; $display("FAIL nop_pc[%0d]: got %0h expected %0h", i, pc_out, 4'(i)); end
    end
    tick();
    checks++; if (pc_out !== 4'h0) begin errors++; $display("FAIL nop_wrap: got %0h expected 0", pc_out); end
    tick();
    checks++; if (pc_out !== 4'h3) begin errors++; $display("FAIL nop_flags_kept: got %0h expected 3", pc_out); end
  endtask

  task automatic test_step();
    do_reset();
    for (int i = 0; i < 16; i++) load_word(4'(i), 8'hD0);
    step_mode = 1'b1;
    pulse_start();
    prog_we = 1'b1; prog_addr = 4'h2; prog_data = 8'hC0;
    tick();
    prog_we = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (pc_out !== 4'h0 || running !== 1'b1) begin errors++; $display("FAIL step_idle: got pc %0h run %0b expected 0 1", pc_out, running); end
    for (int p = 1; p <= 3; p++) begin
      for (int k = 0; k < 4; k++) begin
        tick();
        checks++; if (pc_out !== 4'(p - 1)) begin errors++; $display("FAIL step_hold[%0d]: got %0h expected %0h", p, pc_out, 4'(p - 1)); end
      end
      step = 1'b1;
      tick();
      step = 1'b0;
      checks++; if (pc_out !== 4'(p)) begin errors++; $display("FAIL step_adv[%0d]: got %0h expected %0h", p, pc_out, 4'(p)); end
      if (p == 2) begin
        checks++; if (op !== 8'hD0) begin errors++; $display("FAIL step_write_blocked: got %0h expected d0", op); end
      end
    end
    step_mode = 1'b0;
    tick();
    checks++; if (pc_out !== 4'h4) begin errors++; $display("FAIL step_mode_off: got %0h expected 4", pc_out); end
    step = 1'b1;
    tick();
    step = 1'b0;
    checks++; if (pc_out !== 4'h5) begin errors++; $display("FAIL step_no_extra: got %0h expected 5", pc_out); end
    step_mode = 1'b1;
    tick();
    checks++; if (pc_out !== 4'h5) begin errors++; $display("FAIL step_mode_on: got %0h expected 5", pc_out); end
    step_mode = 1'b0;
  endtask

  task automatic test_opcodes();
    logic [3:0] exp_pc  [0:11];
    logic [3:0] exp_alu [0:8];
    logic [3:0] exp_out [0:11];
    exp_pc  = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hD};
    exp_alu = '{4'h8, 4'h9, 4'h1, 4'h3, 4'h5, 4'h5, 4'h4, 4'h6, 4'h6};
    exp_out = '{4'h0, 4'h0, 4'h0, 4'h3, 4'h3, 4'h5, 4'h5, 4'h5, 4'h6, 4'h6, 4'h6, 4'h6};
    do_reset();
    in_port = 4'h5;
    load_word(4'h0, 8'h23); load_word(4'h1, 8'h41); load_word(4'h2, 8'h58);
    load_word(4'h3, 8'h92); load_word(4'h4, 8'h14); load_word(4'h5, 8'hA0);
    load_word(4'h6, 8'h6F); load_word(4'h7, 8'h76); load_word(4'h8, 8'h90);
    load_word(4'h9, 8'h8C); load_word(4'hA, 8'hED); load_word(4'hD, 8'hC0);
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      checks++; if (pc_out !== exp_pc[i]) begin errors++; $display("FAIL ops_pc[%0d]: got %0h expected %0h", i, pc_out, exp_pc[i]); end
      if (i < 9) begin
        checks++; if (alu_data !== exp_alu[i]) begin errors++; $display("FAIL ops_alu[%0d]: got %0h expected %0h", i, alu_data, exp_alu[i]); end
      end
      tick();
      checks++; if (out_port !== exp_out[i]) begin errors++; $display("FAIL ops_out[%0d]: got %0h expected %0h", i, out_port, exp_out[i]); end
    end
    checks++; if (halted !== 1'b1 || pc_out !== 4'hD) begin errors++; $display("FAIL ops_halt: got halted %0b pc %0h expected 1 d", halted, pc_out); end
  endtask

  task automatic test_wide();
    logic [11:0] prog [0:3];
    logic [4:0]  exp_pc [0:4];
    prog   = '{12'h301, 12'h0FF, 12'hE10, 12'h813};
    exp_pc = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h13};
    for (int i = 0; i < 4; i++) begin
      w_we = 1'b1; w_addr = 5'(i); w_data = prog[i];
      tick();
    end
    w_addr = 5'h13; w_data = 12'hC00;
    tick();
    w_we = 1'b0;
    w_start = 1'b1;
    tick();
    w_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (w_pc !== exp_pc[i]) begin errors++; $display("FAIL wide_pc[%0d]: got %0h expected %0h", i, w_pc, exp_pc[i]); end
      if (i == 1) begin
        checks++; if (w_alu !== 8'h00) begin errors++; $display("FAIL wide_alu_wrap: got %0h expected 00", w_alu); end
      end
      tick();
    end
    checks++; if (w_halted !== 1'b1 || w_pc !== 5'h13) begin errors++; $display("FAIL wide_halt: got halted %0b pc %0h expected 1 13", w_halted, w_pc); end
  endtask

  initial begin
    test_reset();
    test_program();
    test_halt_restart();
    test_reset_midrun();
    test_jmp_loop();
    test_nop_wrap();
    test_step();
    test_opcodes();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdx_cpu.md
TDX_CPU -- requirements
Module: tdx_cpu

Interface
REQ-001 Parameter DATA_W, default 4: width of registers A, B and OUT, of in_port and of the immediate; legal range 4..16.
REQ-002 Parameter PC_W, default 4: program counter width; program memory holds 2^PC_W words; PC_W <= DATA_W is required.
REQ-003 Derived constant INSTR_W = 4 + DATA_W: instruction bits [INSTR_W-1:DATA_W] are the opcode, bits [DATA_W-1:0] are the immediate IM.
REQ-004 clock  in  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 in_port  in  DATA_W  input port.
REQ-007 prog_we  in  1  program-memory write strobe.
REQ-008 prog_addr  in  PC_W  program-memory write address.
REQ-009 prog_data  in  INSTR_W  program-memory write data.
REQ-010 start  in  1  one-cycle pulse that begins execution at PC 0.
REQ-011 step_mode  in  1  1 = single-step execution; 0 = free run.
REQ-012 step  in  1  one-cycle pulse that executes one instruction while step_mode=1.
REQ-013 pc_out  out  PC_W  current PC.
REQ-014 op  out  INSTR_W  instruction word at the current PC.
REQ-015 out_port  out  DATA_W  OUT register.
REQ-016 alu_data  out  DATA_W  current ALU result.
REQ-017 running  out  1  high in the RUN state.
REQ-018 halted  out  1  high in the HALTED state.

Function
REQ-019 State machine with three states:
- LOAD: reset state.
- RUN.
- HALTED.
REQ-020 State transitions:
- LOAD -> RUN on start.
- RUN -> HALTED when a HALT instruction executes.
- HALTED -> RUN on start.
- start is ignored in RUN.
REQ-021 Entering RUN on start: PC <= 0, C <= 0, Z <= 0; A, B and OUT are retained.
REQ-022 prog_we writes prog_data to memory[prog_addr] only in LOAD or HALTED; it is ignored in RUN.
REQ-023 A write and a start in the same cycle are both honoured; the first fetch in RUN returns the newly written word.
REQ-024 Program memory read is combinational (op = memory[PC]); memory contents are not cleared by reset.
REQ-025 ALU: {carry, alu_data} = src + IM, computed at DATA_W+1 bits; src is selected by the opcode (A, B, in_port or zero).
REQ-026 Execution: in RUN with step_mode=0, one instruction executes per cycle; with step_mode=1, an instruction executes only in a cycle where step=1. When no instruction executes, no state changes.
REQ-027 Opcode table (write = ALU result):
- 0000 ADD A,IM: A <= A+IM.
- 0001 MOV A,B: A <= B+IM.
- 0010 IN A: A <= in_port+IM.
- 0011 MOV A,IM: A <= IM.
- 0100 MOV B,A: B <= A+IM.
- 0101 ADD B,IM: B <= B+IM.
- 0110 IN B: B <= in_port+IM.
- 0111 MOV B,IM: B <= IM.
- 1001 OUT B: OUT <= B+IM.
- 1010 OUT A: OUT <= A+IM.
- 1011 OUT IM: OUT <= IM.
- 1000 JZ: jump if Z=1.
- 1110 JNC: jump if C=0.
- 1111 JMP: unconditional jump.
- 1100 HALT.
- 1101 NOP.
REQ-028 Jump target is IM[PC_W-1:0]; a jump that is not taken gives PC <= PC+1.
REQ-029 PC increments modulo 2^PC_W; PC at 2^PC_W-1 wraps to 0.
REQ-030 C and Z are updated only by register-writing opcodes: C <= carry, Z <= (alu_data == 0). Jumps, HALT and NOP preserve both flags.
REQ-031 HALT: PC does not advance; the state becomes HALTED on the next edge, and pc_out keeps the HALT address.
REQ-032 Changing step_mode mid-run takes effect from the next cycle; a step pulse while step_mode=0 has no extra effect.

Reset
REQ-033 Asynchronous reset (reset_n=0) sets: state LOAD, PC 0, A 0, B 0, OUT 0, C 0, Z 0.
REQ-034 Reset during RUN aborts immediately; no register update completes on the clock edge coincident with reset release.
REQ-035 Reset values at the outputs: running=0, halted=0, out_port=0, pc_out=0.

Verification (DATA_W=4, PC_W=4)
REQ-036 Load program {0011_0111, 0000_1001, 1110_0100, 1011_1111, 1011_0001, 1100_0000} at addresses 0..5, then start -> A=7, then A=0 with C=1, JNC not taken, OUT=1, halted=1 with pc_out=5.
REQ-037 Program memory all 1111_0000 (JMP 0), free run -> pc_out stays 0 every cycle; running=1.
REQ-038 Program of NOP in all 16 words -> pc_out runs 0..15 then 0 (wrap); flags unchanged.
REQ-039 step_mode=1, step pulses 5 cycles apart -> exactly one PC change per pulse; prog_we attempted during RUN leaves memory unchanged.
REQ-040 reset_n low mid-run with OUT=0xA -> out_port=0 immediately; state LOAD; memory contents intact; start re-runs the same program.
REQ-041 DATA_W=8, PC_W=5: ADD A,0xFF with A=0x01 -> A=0x00, C=1, Z=1; next JZ 0x13 -> pc_out=0x13.
